// File: rtl/rat_mul_div_pipe.sv
// rat_mul_div_pipe
//   Pipelined rational multiply/divide: s = l * r or s = l / r on signed
//   numerator/denominator pairs. No GCD reduction, no rounding. The result
//   denominator is made non-negative. Results are truncated to WIDTH bits.
//
//   Optional feature macro: RAT_MULDIV_OVF_EN
//     defined   -> ovf flags results whose normalised products do not
//                  sign-fit in WIDTH bits
//     undefined -> ovf tied to 0
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake
//   enable_div                1 = divide, 0 = multiply (per transaction)
//   l_num,l_den,r_num,r_den   operands, WIDTH-bit two's complement
//   out_valid/out_ready       result handshake
//   s_num,s_den               result (truncated to WIDTH bits)
//   zero_den                  full-width result denominator is zero
//   ovf                       result not representable in WIDTH bits
module rat_mul_div_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable_div,
  input  logic [WIDTH-1:0] l_num,
  input  logic [WIDTH-1:0] l_den,
  input  logic [WIDTH-1:0] r_num,
  input  logic [WIDTH-1:0] r_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_num,
  output logic [WIDTH-1:0] s_den,
  output logic             zero_den,
  output logic             ovf
);

  localparam int W2 = 2 * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             zd;
    logic             ovf;
  } res_t;

  // Global advance: the whole pipe moves together whenever the output slot
  // is empty or being drained, so bubbles are never squeezed out.
  logic advance;
  logic in_fire;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign in_fire  = in_valid && in_ready;

  logic [STAGES:1] vld_pipe_q;

  // Stage 1: operand selection. Division by r is multiplication by r's
  // reciprocal, so r_num/r_den swap roles.
  logic signed [WIDTH-1:0] a_q, b_q, c_q, d_q;

  // Stage 2 combinational: full-width products and sign normalisation.
  logic signed [W2-1:0] p_raw, q_raw, p_n, q_n;
  logic                 ovf_n;
  res_t                 res_n;

  assign p_raw = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign q_raw = $signed({{WIDTH{c_q[WIDTH-1]}}, c_q}) * $signed({{WIDTH{d_q[WIDTH-1]}}, d_q});
  // |product| <= 2^(2W-2), so negation at 2W bits cannot wrap.
  assign p_n   = q_raw[W2-1] ? -p_raw : p_raw;
  assign q_n   = q_raw[W2-1] ? -q_raw : q_raw;

`ifdef RAT_MULDIV_OVF_EN
  // A value sign-fits in WIDTH bits when bits [2W-1:W-1] are all equal.
  function automatic logic sfits(input logic [W2-1:0] x);
    logic [WIDTH:0] top;
    top = x[W2-1:WIDTH-1];
    return (&top) | (~|top);
  endfunction
  assign ovf_n = !sfits(p_n) || !sfits(q_n);
`else
  logic unused_p_hi;
  assign ovf_n       = 1'b0;
  assign unused_p_hi = ^p_n[W2-1:WIDTH];
`endif

  assign res_n.num = p_n[WIDTH-1:0];
  assign res_n.den = q_n[WIDTH-1:0];
  assign res_n.zd  = (q_n == '0);
  assign res_n.ovf = ovf_n;

  // Stages 2..STAGES: result registers; 3..STAGES are pure retiming delay.
  res_t res_q [STAGES:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      for (int k = 2; k <= STAGES; k++) res_q[k] <= '0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_fire};
      a_q        <= l_num;
      b_q        <= enable_div ? r_den : r_num;
      c_q        <= l_den;
      d_q        <= enable_div ? r_num : r_den;
      res_q[2]   <= res_n;
      for (int k = 3; k <= STAGES; k++) res_q[k] <= res_q[k-1];
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign s_num     = res_q[STAGES].num;
  assign s_den     = res_q[STAGES].den;
  assign zero_den  = res_q[STAGES].zd;
  assign ovf       = res_q[STAGES].ovf;

endmodule

// File: doc/rat_mul_div_pipe.md
# rat_mul_div_pipe

Pipelined, parametrised rational multiply/divide unit for the rational arithmetic datapath. It computes s = l × r or s = l ÷ r on signed two's-complement numerator/denominator pairs. Each pair flows through a configurable-depth pipeline with valid/ready handshakes and backpressure. Each result carries a positive-denominator sign normalisation and status flags for a zero denominator and, optionally, overflow.

## Interface
- WIDTH, 32, bit width of every numerator/denominator (signed two's complement), ≥ 2
- STAGES, 2, pipeline depth = accept-to-output latency in cycles, ≥ 2
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  unit accepts a pair this cycle
- enable_div  in  1  1 = divide (s = l ÷ r), 0 = multiply; sampled with operands
- l_num, l_den, r_num, r_den  in  WIDTH each  operands
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result this cycle
- s_num, s_den  out  WIDTH each  result
- zero_den  out  1  result denominator is zero
- ovf  out  1  result not representable in WIDTH bits (see Configuration)

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global-advance pipeline: advance = !out_valid || out_ready; in_ready = advance && !rst. On advance all stages shift by one; a stage without a transfer shifts in a bubble (valid=0). Without advance, all stages hold.
- Stage 1 registers the operand selection and the valid bit: a = l_num, b = enable_div ? r_den : r_num, c = l_den, d = enable_div ? r_num : r_den.
- Stage 2 registers the full 2·WIDTH signed products P = a·b and Q = c·d, then the normalisation: if Q < 0, P = −P and Q = −Q. Negation is done at 2·WIDTH, so it cannot overflow.
- Stages 3..STAGES are pure delay registers for retiming; they hold data, flags and valid.
- Output: s_num = P[WIDTH-1:0], s_den = Q[WIDTH-1:0] (truncation).
- zero_den = (Q == 0), evaluated on the full product.
- No GCD reduction and no rounding.
- Results leave in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (rst high at a posedge): every stage valid bit clears, out_valid = 0, s_num = s_den = 0, zero_den = ovf = 0. in_ready = 0 while rst is high and 1 on the first cycle after.
- Reset mid-operation discards all in-flight pairs; no result from before reset is ever presented.
- Latency: a pair accepted at edge t appears with out_valid = 1 after edge t+STAGES−1, i.e. STAGES cycles of register delay, provided out_ready stays high.
- Throughput: one pair per cycle with out_ready held high.
- While out_valid && !out_ready: s_num, s_den, zero_den and ovf are stable and in_ready = 0.
- Simultaneous out transfer and in transfer in the same cycle is allowed and is the steady-state case.
- in_valid has no effect while in_ready = 0. The upstream block holds its data until it sees a transfer.
- enable_div is per transaction. Changing it between consecutive pairs needs no bubble.

## Configuration
- RAT_MULDIV_OVF_EN defined:
  - ovf = 1 when the normalised P or Q does not sign-fit in WIDTH bits, i.e. bits [2·WIDTH−1:WIDTH−1] of P or of Q are not all equal.
  - ovf is computed in stage 2 and travels with its result.
  - s_num and s_den are still the truncated values.
- RAT_MULDIV_OVF_EN undefined: ovf is tied to 0 and no overflow comparison logic is built. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, STAGES=3, RAT_MULDIV_OVF_EN defined.
- Multiply, out_ready=1: 3/4 × (−2)/5 accepted at edge 0 → after edge 2, out_valid=1, s=−6/20, zero_den=0, ovf=0.
- Divide with sign normalisation: 3/4 ÷ (−2)/5 → s = 15/−8 normalised to −15/8; (−1)/(−3) × 1/1 → 1/3.
- Zero denominator and overflow:
  - 5/7 ÷ 0/3 → s = 15/0, zero_den=1.
  - 16/1 × 16/1 → P = 256: ovf=1, s_num=0x00, s_den=1.
  - −128/1 × −1/1 → ovf=1.
  - With the macro undefined, the same vectors give ovf=0.
- Backpressure: stream 6 pairs back-to-back while out_ready=0 for cycles 3–7 → in_ready drops once the pipeline is full, the output holds stable, all 6 results arrive in order with none lost or duplicated, and ovf/zero_den stay aligned with their data.
- Alternating mode: pairs with enable_div = 0,1,0,1 on consecutive cycles → each result matches its own mode and there are no bubbles.
- Reset mid-flight: assert rst for 1 cycle with 3 pairs in flight → out_valid=0 the next cycle, those results never appear, in_ready=1 one cycle after rst falls, and the next pair returns after 3 cycles.
